// File: rtl/tff_count_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tff_count_pkg                                             |
// | Purpose  : Shared constants for the T-FF counter controller:         |
// |            default bank width and controller state encoding.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package tff_count_pkg;

   // Default number of T flip-flops in the bank.
   localparam int c_WIDTH = 4;

   // Controller state encoding.
   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_LOAD = 2'd1;
   localparam logic [1:0] c_RUN  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/tff_count_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tff_count_ctrl_if                                         |
// | Purpose  : Command/status bundle between higher-level control and    |
// |            the T-FF counter controller.                              |
// | Ports    : master drives start/dir/limit/pause/abort and observes    |
// |            count/toggle/busy/done; slave is the controller side.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface tff_count_ctrl_if
   import tff_count_pkg::*;
#(
   parameter int WIDTH = c_WIDTH
);
   logic             start;
   logic             dir;
   logic [WIDTH-1:0] limit;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] toggle;
   logic             busy;
   logic             done;

   modport master (
      output start, dir, limit, pause, abort,
      input  count, toggle, busy, done
   );

   modport slave (
      input  start, dir, limit, pause, abort,
      output count, toggle, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/t_ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : t_ff                                                      |
// | Purpose  : Single toggle flip-flop with synchronous active-high      |
// |            reset.                                                    |
// | Ports    : clk, reset, t (toggle enable), q (state).                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module t_ff (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic t,
   output logic      q
);
   logic r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= 1'b0;
      end else if (t) begin
         r_q <= ~r_q;
      end
   end

   assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/tff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tff_bank                                                  |
// | Purpose  : WIDTH independent T flip-flops sharing clock and reset.   |
// | Ports    : clk, reset, t[WIDTH-1:0] toggle inputs,                   |
// |            q[WIDTH-1:0] bank state.                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tff_bank
   import tff_count_pkg::*;
#(
   parameter int WIDTH = c_WIDTH
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic [WIDTH-1:0] t,
   output logic      [WIDTH-1:0] q
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff u_tff (
         .clk   (clk),
         .reset (reset),
         .t     (t[i]),
         .q     (q[i])
      );
   end
endmodule
`default_nettype wire

// File: rtl/tff_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tff_count_ctrl                                            |
// | Purpose  : Sequencing controller for a bank of T flip-flops. A start |
// |            request loads an initial value, then the bank counts up   |
// |            to limit or down to zero, with pause and abort support.   |
// | Ports    : clk, reset (sync, active-high),                           |
// |            bus (slave): start/dir/limit/pause/abort in,              |
// |                         count/toggle/busy/done out.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tff_count_ctrl
   import tff_count_pkg::*;
#(
   parameter int WIDTH = c_WIDTH
) (
   input wire logic        clk,
   input wire logic        reset,
   tff_count_ctrl_if.slave bus
);
   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic             r_dir;
   logic [WIDTH-1:0] r_init;
   logic [WIDTH-1:0] r_target;

   logic [WIDTH-1:0] w_count;
   logic [WIDTH-1:0] w_toggle;
   logic [WIDTH-1:0] w_up_t;
   logic [WIDTH-1:0] w_dn_t;
   logic             w_at_target;
   logic             w_busy;
   logic             w_done;

   // ---------------------------------------------------------------
   // Operation parameters, captured only when a start is accepted.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dir    <= 1'b0;
         r_init   <= '0;
         r_target <= '0;
      end else if ((r_state == c_IDLE) && bus.start) begin
         r_dir    <= bus.dir;
         r_init   <= bus.dir ? bus.limit : '0;
         r_target <= bus.dir ? '0 : bus.limit;
      end
   end

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   assign w_at_target = (w_count == r_target);

   // ---------------------------------------------------------------
   // Next-state logic. In RUN, abort cancels even when the target has
   // just been reached, so an aborted operation never reports done.
   // ---------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: if (bus.start) w_next_state = c_LOAD;
         c_LOAD: w_next_state = bus.abort ? c_IDLE : c_RUN;
         c_RUN: begin
            if (bus.abort) begin
               w_next_state = c_IDLE;
            end else if (w_at_target) begin
               w_next_state = c_DONE;
            end
         end
         c_DONE:  w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Ripple toggle patterns: bit i flips when all lower bits are 1
   // (increment) or all lower bits are 0 (decrement).
   // ---------------------------------------------------------------
   assign w_up_t[0] = 1'b1;
   assign w_dn_t[0] = 1'b1;

   for (genvar i = 1; i < WIDTH; i++) begin : g_step
      assign w_up_t[i] = &w_count[i-1:0];
      assign w_dn_t[i] = &(~w_count[i-1:0]);
   end

   // ---------------------------------------------------------------
   // Output logic. In LOAD the toggle vector is the XOR difference,
   // so the bank lands on the initial value in a single edge.
   // ---------------------------------------------------------------
   always_comb begin
      w_toggle = '0;
      w_busy   = 1'b0;
      w_done   = 1'b0;
      case (r_state)
         c_LOAD: begin
            w_busy = 1'b1;
            if (!bus.abort) begin
               w_toggle = w_count ^ r_init;
            end
         end
         c_RUN: begin
            w_busy = 1'b1;
            if (!bus.abort && !w_at_target && !bus.pause) begin
               w_toggle = r_dir ? w_dn_t : w_up_t;
            end
         end
         c_DONE: begin
            w_done = 1'b1;
         end
         default: begin
            w_toggle = '0;
         end
      endcase
   end

   tff_bank #(
      .WIDTH (WIDTH)
   ) u_bank (
      .clk   (clk),
      .reset (reset),
      .t     (w_toggle),
      .q     (w_count)
   );

   assign bus.count  = w_count;
   assign bus.toggle = w_toggle;
   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
endmodule
`default_nettype wire

// File: tb/tb_tff_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tff_count_ctrl                                         |
// | Purpose  : Self-checking bench for tff_count_ctrl: vector table,     |
// |            directed multi-cycle sequences and random stimulus        |
// |            against an arithmetic reference model.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tff_count_ctrl;
   logic clk   = 1'b0;
   logic reset = 1'b1;

   tff_count_ctrl_if #(.WIDTH(4)) bus ();

   tff_count_ctrl #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase 0 idle, 1 load, 2 run, 3 done.
   int         m_ph  = 0;
   logic [3:0] m_cnt = 4'd0;
   logic [3:0] m_init = 4'd0;
   logic [3:0] m_tgt = 4'd0;
   bit         m_dir = 1'b0;

   // Last observation taken by cyc().
   logic [3:0] oc, ot;
   logic       ob, od;

   typedef struct {
      bit         r, s, d;
      logic [3:0] l;
      bit         p, a;
      logic [3:0] ec, et;
      bit         eb, ed;
   } vec_t;

   vec_t tbl[19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Toggle is the XOR between the present and the next count value.
   function automatic logic [3:0] m_tog(input bit p, input bit a);
      logic [3:0] nxt;
      if (m_ph == 1 && !a) return m_cnt ^ m_init;
      if (m_ph == 2 && !a && m_cnt != m_tgt && !p) begin
         nxt = m_dir ? m_cnt - 4'd1 : m_cnt + 4'd1;
         return m_cnt ^ nxt;
      end
      return 4'd0;
   endfunction

   task automatic m_step(input bit r, input bit s, input bit d, input logic [3:0] l,
                         input bit p, input bit a);
      logic [3:0] old;
      logic [3:0] t;
      old = m_cnt;
      t   = m_tog(p, a);
      if (r) begin
         m_ph  = 0;
         m_cnt = 4'd0;
         return;
      end
      m_cnt = m_cnt ^ t;
      if (m_ph == 0) begin
         if (s) begin
            m_dir  = d;
            m_init = d ? l : 4'd0;
            m_tgt  = d ? 4'd0 : l;
            m_ph   = 1;
         end
      end else if (m_ph == 1) begin
         m_ph = a ? 0 : 2;
      end else if (m_ph == 2) begin
         if (a) m_ph = 0;
         else if (old == m_tgt) m_ph = 3;
      end else begin
         m_ph = 0;
      end
   endtask

   // One clock cycle: drive inputs, observe (and optionally model-check)
   // the outputs, advance the model, then cross the rising edge.
   task automatic cyc(input bit r, input bit s, input bit d, input logic [3:0] l,
                      input bit p, input bit a, input bit mchk);
      reset     = r;
      bus.start = s;
      bus.dir   = d;
      bus.limit = l;
      bus.pause = p;
      bus.abort = a;
      #2;
      oc = bus.count;
      ot = bus.toggle;
      ob = bus.busy;
      od = bus.done;
      if (mchk) begin
         chk("model_count",  32'(oc), 32'(m_cnt));
         chk("model_toggle", 32'(ot), 32'(m_tog(p, a)));
         chk("model_busy",   32'(ob), 32'(m_ph == 1 || m_ph == 2));
         chk("model_done",   32'(od), 32'(m_ph == 3));
      end
      m_step(r, s, d, l, p, a);
      @(posedge clk);
      #1;
   endtask

   // Run one operation. edges = number of edges after the start edge at
   // which done was observed; pause held plen cycles while count==pcnt;
   // abort raised while count==acnt (-1 disables either).
   task automatic op(input bit d, input logic [3:0] l, input int pcnt, input int plen,
                     input int acnt, output int edges, output bit got,
                     output logic [3:0] dcnt, output logic [3:0] dtog);
      int left;
      bit p, a;
      left  = plen;
      got   = 1'b0;
      edges = -1;
      dcnt  = 4'd0;
      dtog  = 4'd0;
      cyc(0, 1, d, l, 0, 0, 1);
      for (int i = 0; i < 64; i++) begin
         p = (left > 0) && (m_ph == 2) && (int'(m_cnt) == pcnt);
         if (p) left--;
         a = (m_ph == 2) && (int'(m_cnt) == acnt);
         cyc(0, 0, 0, 4'd0, p, a, 1);
         if (od) begin
            got   = 1'b1;
            edges = i;
            dcnt  = oc;
            dtog  = ot;
            break;
         end
         if (a) break;
      end
   endtask

   initial begin
      int         e, r1, r2;
      bit         g, prev;
      logic [3:0] dc, dt;

      //                r  s  d  l      p  a   count  toggle busy done
      tbl[0]  = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0, 4'd0, 1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b1,1'b0,4'd2,1'b0,1'b0, 4'd0, 4'd0, 1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0, 4'd0, 1'b1,1'b0};
      tbl[3]  = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0, 4'd1, 1'b1,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd1, 4'd3, 1'b1,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd2, 4'd0, 1'b1,1'b0};
      tbl[6]  = '{1'b0,1'b1,1'b1,4'd7,1'b0,1'b0, 4'd2, 4'd0, 1'b0,1'b1};
      tbl[7]  = '{1'b0,1'b1,1'b1,4'd3,1'b0,1'b0, 4'd2, 4'd0, 1'b0,1'b0};
      tbl[8]  = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd2, 4'd1, 1'b1,1'b0};
      tbl[9]  = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd3, 4'd1, 1'b1,1'b0};
      tbl[10] = '{1'b0,1'b0,1'b0,4'd0,1'b1,1'b0, 4'd2, 4'd0, 1'b1,1'b0};
      tbl[11] = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd2, 4'd3, 1'b1,1'b0};
      tbl[12] = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b1, 4'd1, 4'd0, 1'b1,1'b0};
      tbl[13] = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd1, 4'd0, 1'b0,1'b0};
      tbl[14] = '{1'b0,1'b1,1'b0,4'd0,1'b0,1'b0, 4'd1, 4'd0, 1'b0,1'b0};
      tbl[15] = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd1, 4'd1, 1'b1,1'b0};
      tbl[16] = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0, 4'd0, 1'b1,1'b0};
      tbl[17] = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0, 4'd0, 1'b0,1'b1};
      tbl[18] = '{1'b0,1'b0,1'b0,4'd0,1'b0,1'b0, 4'd0, 4'd0, 1'b0,1'b0};

      // Reset for two cycles.
      cyc(1, 0, 0, 4'd0, 0, 0, 0);
      cyc(1, 0, 0, 4'd0, 0, 0, 0);

      // Vector table.
      for (int i = 0; i < 19; i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].l, tbl[i].p, tbl[i].a, 0);
         chk($sformatf("vec%0d_count", i),  32'(oc), 32'(tbl[i].ec));
         chk($sformatf("vec%0d_toggle", i), 32'(ot), 32'(tbl[i].et));
         chk($sformatf("vec%0d_busy", i),   32'(ob), 32'(tbl[i].eb));
         chk($sformatf("vec%0d_done", i),   32'(od), 32'(tbl[i].ed));
      end

      // Reset asserted mid-RUN clears everything one edge later.
      cyc(0, 1, 0, 4'd9, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 4'd0, 0, 0, 1);
      cyc(1, 0, 0, 4'd0, 0, 0, 1);
      cyc(0, 0, 0, 4'd0, 0, 0, 1);
      chk("midrun_reset_count",  32'(oc), 32'd0);
      chk("midrun_reset_toggle", 32'(ot), 32'd0);
      chk("midrun_reset_busy",   32'(ob), 32'd0);
      chk("midrun_reset_done",   32'(od), 32'd0);

      // Up count to 9.
      op(0, 4'd9, -1, 0, -1, e, g, dc, dt);
      chk("up9_done_seen", 32'(g), 32'd1);
      chk("up9_latency", e, 32'd11);
      chk("up9_final_count", 32'(dc), 32'd9);
      chk("up9_done_toggle", 32'(dt), 32'd0);

      // Down count from 5 with the bank left at 9.
      cyc(0, 1, 1, 4'd5, 0, 0, 1);
      cyc(0, 0, 0, 4'd0, 0, 0, 1);
      chk("down5_load_toggle", 32'(ot), 32'b1100);
      e = -1;
      for (int i = 1; i < 40; i++) begin
         cyc(0, 0, 0, 4'd0, 0, 0, 1);
         if (i == 1) chk("down5_load_count", 32'(oc), 32'd5);
         if (od) begin
            e = i;
            break;
         end
      end
      chk("down5_latency", e, 32'd7);
      chk("down5_final_count", 32'(oc), 32'd0);

      // Full-range up count, no wrap.
      op(0, 4'hF, -1, 0, -1, e, g, dc, dt);
      chk("up15_latency", e, 32'd17);
      chk("up15_final_count", 32'(dc), 32'd15);

      // Pause held 3 cycles at count 3.
      op(0, 4'd6, 3, 3, -1, e, g, dc, dt);
      chk("pause_latency", e, 32'd11);
      chk("pause_final_count", 32'(dc), 32'd6);

      // Abort at count 4.
      op(0, 4'd9, -1, 0, 4, e, g, dc, dt);
      chk("abort_no_done", 32'(g), 32'd0);
      cyc(0, 0, 0, 4'd0, 0, 0, 1);
      chk("abort_busy", 32'(ob), 32'd0);
      chk("abort_count", 32'(oc), 32'd4);
      g = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 4'd0, 0, 0, 1);
         if (od) g = 1'b1;
      end
      chk("abort_done_quiet", 32'(g), 32'd0);

      // limit = 0.
      op(0, 4'd0, -1, 0, -1, e, g, dc, dt);
      chk("lim0_latency", e, 32'd2);
      chk("lim0_final_count", 32'(dc), 32'd0);

      // start held high: operations are spaced limit+4 cycles apart.
      prev = 1'b0;
      r1 = -1;
      r2 = -1;
      for (int i = 0; i < 16; i++) begin
         cyc(0, 1, 0, 4'd1, 0, 0, 1);
         if (ob && !prev) begin
            if (r1 < 0) r1 = i;
            else if (r2 < 0) r2 = i;
         end
         prev = ob;
      end
      chk("held_start_spacing", r2 - r1, 32'd5);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 4'd0, 0, 0, 1);

      // start during RUN is ignored; latched limit is kept.
      cyc(0, 1, 0, 4'd5, 0, 0, 1);
      e = -1;
      for (int i = 0; i < 40; i++) begin
         cyc(0, (i == 3), 0, (i == 3) ? 4'd12 : 4'd0, 0, 0, 1);
         if (od) begin
            e = i;
            break;
         end
      end
      chk("run_start_latency", e, 32'd7);
      chk("run_start_final_count", 32'(oc), 32'd5);

      // Random stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(63, 0) == 0), ($urandom_range(3, 0) == 0),
             1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
             ($urandom_range(4, 0) == 0), ($urandom_range(15, 0) == 0), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
`default_nettype wire
